// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter sharing one data-memory port
module mem_arbiter #(
    parameter int Xlen           = 64,
    parameter int MaskBits       = Xlen / 8,
    parameter int MaxOutstanding = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                if_valid_i,
    output logic                if_ready_o,
    input  logic [Xlen-1:0]     if_addr_i,
    output logic                if_rvalid_o,
    output logic [Xlen-1:0]     if_rdata_o,
    input  logic                lsu_valid_i,
    output logic                lsu_ready_o,
    input  logic [Xlen-1:0]     lsu_addr_i,
    output logic                lsu_rvalid_o,
    output logic [Xlen-1:0]     lsu_rdata_o,
    input  logic [Xlen-1:0]     lsu_wdata_i,
    input  logic [MaskBits-1:0] lsu_wmask_i,
    output logic                mem_valid_o,
    input  logic                mem_ready_i,
    output logic [Xlen-1:0]     mem_addr_o,
    output logic [Xlen-1:0]     mem_wdata_o,
    output logic [MaskBits-1:0] mem_wmask_o,
    input  logic                mem_rvalid_i,
    input  logic [Xlen-1:0]     mem_rdata_i,
    output logic                err_o
);
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    typedef enum logic [1:0] {
        UNLOCKED   = 2'd0,
        LOCKED_IF  = 2'd1,
        LOCKED_LSU = 2'd2
    } lock_t;

    lock_t           lock_q, lock_d;
    logic            last_q;              // 0 = fetch, 1 = LSU
    logic [CntW-1:0] cnt_q;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic            id_fifo_q [MaxOutstanding];

    logic sel_lsu, issue_ok, push, pop, fifo_empty, head_lsu;

    assign issue_ok   = cnt_q < CntW'(MaxOutstanding);
    assign fifo_empty = (cnt_q == '0);
    assign head_lsu   = id_fifo_q[rd_ptr_q];

    always_comb begin
        sel_lsu = 1'b0;
        lock_d  = lock_q;
        case (lock_q)
            LOCKED_IF:  sel_lsu = 1'b0;
            LOCKED_LSU: sel_lsu = 1'b1;
            default: begin
                if (if_valid_i && lsu_valid_i) sel_lsu = ~last_q;
                else                           sel_lsu = lsu_valid_i;
            end
        endcase

        mem_valid_o = !rst_i && issue_ok && (sel_lsu ? lsu_valid_i : if_valid_i);
        push        = mem_valid_o && mem_ready_i;
        // Pop decision uses the pre-push count, so a same-cycle accept cannot be answered.
        pop         = !rst_i && mem_rvalid_i && !fifo_empty;

        mem_addr_o  = sel_lsu ? lsu_addr_i  : if_addr_i;
        mem_wdata_o = sel_lsu ? lsu_wdata_i : '0;
        mem_wmask_o = sel_lsu ? lsu_wmask_i : '0;

        if_ready_o   = push && !sel_lsu;
        lsu_ready_o  = push && sel_lsu;
        if_rvalid_o  = pop && !head_lsu;
        lsu_rvalid_o = pop && head_lsu;
        if_rdata_o   = mem_rdata_i;
        lsu_rdata_o  = mem_rdata_i;

        if (push)             lock_d = UNLOCKED;
        else if (mem_valid_o) lock_d = sel_lsu ? LOCKED_LSU : LOCKED_IF;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lock_q <= UNLOCKED;
        else       lock_q <= lock_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q   <= 1'b0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_o    <= 1'b0;
            for (int i = 0; i < MaxOutstanding; i++) id_fifo_q[i] <= 1'b0;
        end else begin
            if (push) begin
                id_fifo_q[wr_ptr_q] <= sel_lsu;
                last_q              <= sel_lsu;
                wr_ptr_q <= (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
            if (mem_rvalid_i && fifo_empty) err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, if_ready, if_rvalid;
    logic [63:0] if_addr, if_rdata;
    logic        lsu_valid, lsu_ready, lsu_rvalid;
    logic [63:0] lsu_addr, lsu_rdata, lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        mem_valid, mem_ready, mem_rvalid, err;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.Xlen(64), .MaskBits(8), .MaxOutstanding(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_valid_i(if_valid), .if_ready_o(if_ready), .if_addr_i(if_addr),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_addr_i(lsu_addr),
        .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata),
        .lsu_wdata_i(lsu_wdata), .lsu_wmask_i(lsu_wmask),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .err_o(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        if_valid = 1'b1; if_addr = '0;
        lsu_valid = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = '0;
        #3;
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_err", err, 0);
        if_valid = 1'b0; mem_rvalid = 1'b0;
        nxt();
        rst = 1'b0;

        // fetch-only request, response two cycles later
        if_valid = 1'b1; if_addr = 64'h1000; #3;
        chk("t1_if_ready", if_ready, 1);
        chk("t1_mem_addr", mem_addr, 64'h1000);
        chk("t1_mem_wmask", mem_wmask, 0);
        nxt(); if_valid = 1'b0; #3;
        chk("t1_no_rvalid", if_rvalid, 0);
        nxt(); mem_rvalid = 1'b1; mem_rdata = 64'hDEAD; #3;
        chk("t1_if_rvalid", if_rvalid, 1);
        chk("t1_if_rdata", if_rdata, 64'hDEAD);
        chk("t1_lsu_rvalid", lsu_rvalid, 0);
        nxt(); mem_rvalid = 1'b0;

        // both valid continuously: LSU, IF, stall, LSU (with same-cycle response), IF
        if_valid = 1'b1; lsu_valid = 1'b1; if_addr = 64'hA0; lsu_addr = 64'hB0; #3;
        chk("t2_g1_lsu", lsu_ready, 1);
        chk("t2_g1_if", if_ready, 0);
        nxt(); #3;
        chk("t2_g2_if", if_ready, 1);
        chk("t2_g2_lsu", lsu_ready, 0);
        nxt(); mem_rvalid = 1'b1; mem_rdata = 64'h5; #3;
        chk("t2_stall_valid", mem_valid, 0);
        chk("t2_stall_lsu_ready", lsu_ready, 0);
        chk("t2_resp_lsu", lsu_rvalid, 1);
        nxt(); #3;
        chk("t2_g3_lsu", lsu_ready, 1);
        chk("t2_same_cycle_if_rvalid", if_rvalid, 1);
        chk("t2_same_cycle_lsu_rvalid", lsu_rvalid, 0);
        nxt(); mem_rvalid = 1'b0; #3;
        chk("t2_g4_if", if_ready, 1);
        nxt(); #3;
        chk("t2_full_stall", mem_valid, 0);
        if_valid = 1'b0; lsu_valid = 1'b0; mem_rvalid = 1'b1; #1;
        chk("t2_drain_lsu", lsu_rvalid, 1);
        nxt(); #3;
        chk("t2_drain_if", if_rvalid, 1);
        nxt(); mem_rvalid = 1'b0;

        // interleaved IF then LSU, responses 0x11 then 0x22
        if_valid = 1'b1; if_addr = 64'h10; #3;
        chk("t4_if_ready", if_ready, 1);
        nxt(); if_valid = 1'b0; lsu_valid = 1'b1; lsu_addr = 64'h20; #3;
        chk("t4_lsu_ready", lsu_ready, 1);
        nxt(); lsu_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h11; #3;
        chk("t4_r1_if", if_rvalid, 1);
        chk("t4_r1_lsu", lsu_rvalid, 0);
        chk("t4_r1_data", if_rdata, 64'h11);
        nxt(); mem_rdata = 64'h22; #3;
        chk("t4_r2_lsu", lsu_rvalid, 1);
        chk("t4_r2_if", if_rvalid, 0);
        chk("t4_r2_data", lsu_rdata, 64'h22);
        nxt(); mem_rvalid = 1'b0;

        // LSU store held for 3 cycles; fetch joins but must wait for the lock
        mem_ready = 1'b0; lsu_valid = 1'b1; lsu_addr = 64'h2000;
        lsu_wdata = 64'hCAFE; lsu_wmask = 8'hF0; if_addr = 64'h3000;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) if_valid = 1'b1;
            if (c == 3) mem_ready = 1'b1;
            #3;
            chk("t3_addr", mem_addr, 64'h2000);
            chk("t3_wdata", mem_wdata, 64'hCAFE);
            chk("t3_wmask", {56'd0, mem_wmask}, 64'hF0);
            chk("t3_if_ready", if_ready, 0);
            chk("t3_lsu_ready", lsu_ready, (c == 3) ? 1 : 0);
            nxt();
        end
        lsu_valid = 1'b0; #3;
        chk("t3_if_granted", if_ready, 1);
        chk("t3_if_addr", mem_addr, 64'h3000);
        chk("t3_if_wmask", {56'd0, mem_wmask}, 0);
        nxt(); if_valid = 1'b0; mem_rvalid = 1'b1; #3;
        chk("t3_resp_lsu", lsu_rvalid, 1);
        nxt(); #3;
        chk("t3_resp_if", if_rvalid, 1);
        nxt(); mem_rvalid = 1'b0;

        // spurious response with nothing outstanding
        mem_rvalid = 1'b1; #3;
        chk("t6_spur_if", if_rvalid, 0);
        chk("t6_spur_lsu", lsu_rvalid, 0);
        nxt(); mem_rvalid = 1'b0; #3;
        chk("t6_err_set", err, 1);
        nxt(); #3;
        chk("t6_err_held", err, 1);

        // lock on LSU, then assert reset mid-handshake
        lsu_valid = 1'b1; mem_ready = 1'b0;
        nxt(); mem_rvalid = 1'b1; rst = 1'b1; #1;
        chk("t6_rst_mem_valid", mem_valid, 0);
        chk("t6_rst_lsu_ready", lsu_ready, 0);
        chk("t6_rst_rvalid", lsu_rvalid | if_rvalid, 0);
        chk("t6_rst_err", err, 0);
        nxt(); rst = 1'b0; mem_rvalid = 1'b0; if_valid = 1'b1; mem_ready = 1'b1; #3;
        chk("t6_post_rst_tie_lsu", lsu_ready, 1);
        chk("t6_post_rst_if", if_ready, 0);
        nxt(); if_valid = 1'b0; lsu_valid = 1'b0;
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
